// File: rtl/class_hasht_pio_bridge.sv
// class_hasht_pio_bridge: PIO front end to the hash-table arbiter with lane staging and ack timeout
module class_hasht_pio_bridge #(
  parameter int PIO_NBITS = 32,
  parameter int CLASSIFIER_PIO_MEM_ADDR_WIDTH = 17,
  parameter int DW = 128,
  parameter int TIMEOUT = 64,
  parameter logic [PIO_NBITS-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF,
  parameter logic RD = 1'b1,
  parameter logic WR = 1'b0
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     pio_req,
  input  logic                                     pio_rd_or_wr,
  input  logic [CLASSIFIER_PIO_MEM_ADDR_WIDTH-1:0] pio_addr,
  input  logic [PIO_NBITS-1:0]                     pio_wdata,
  output logic                                     pio_ack,
  output logic [PIO_NBITS-1:0]                     pio_rdata,
  output logic                                     busy,
  output logic                                     req,
  output logic                                     rd_or_wr,
  output logic [CLASSIFIER_PIO_MEM_ADDR_WIDTH-1:0] addr,
  output logic [DW-1:0]                            wdata,
  input  logic                                     ack,
  input  logic [PIO_NBITS-1:0]                     rdata,
  output logic                                     err_timeout,
  output logic                                     err_overrun,
  output logic                                     err_stray,
  input  logic                                     err_clr
);
  localparam int CW = $clog2(TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t                     r_state;
  logic [3*PIO_NBITS-1:0]     r_stage;
  logic [CW-1:0]              r_cnt;
  logic [1:0]                 w_lane;
  logic                       w_to;
  logic                       w_short_wr;
  assign w_lane     = pio_addr[3:2];
  assign w_short_wr = (pio_rd_or_wr == WR) && (w_lane != 2'd3);
  // r_cnt holds the number of WAIT cycles already elapsed; a zero TIMEOUT still allows one WAIT cycle
  assign w_to       = int'(r_cnt) + 1 >= TIMEOUT;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_stage     <= '0;
      r_cnt       <= '0;
      pio_ack     <= 1'b0;
      pio_rdata   <= '0;
      busy        <= 1'b0;
      req         <= 1'b0;
      rd_or_wr    <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      err_stray   <= 1'b0;
    end else begin
      pio_ack     <= 1'b0;
      pio_rdata   <= '0;
      req         <= 1'b0;
      err_overrun <= (pio_req && r_state != IDLE) || (err_overrun && !err_clr);
      err_stray   <= (ack && r_state != WAIT) || (err_stray && !err_clr);
      err_timeout <= (r_state == WAIT && !ack && w_to) || (err_timeout && !err_clr);
      case (r_state)
        IDLE: if (pio_req) begin
          busy <= 1'b1;
          if (w_short_wr) begin
            r_stage[w_lane*PIO_NBITS +: PIO_NBITS] <= pio_wdata;
            pio_ack <= 1'b1;
            r_state <= RESP;
          end else begin
            addr     <= pio_addr;
            rd_or_wr <= pio_rd_or_wr;
            req      <= 1'b1;
            r_state  <= ISSUE;
            if (pio_rd_or_wr == WR) wdata <= {pio_wdata, r_stage};
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (ack || w_to) begin
            pio_ack   <= 1'b1;
            pio_rdata <= ack ? ((rd_or_wr == RD) ? rdata : '0) : TIMEOUT_DATA;
            r_state   <= RESP;
          end
        end
        RESP: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_class_hasht_pio_bridge.sv
// tb_class_hasht_pio_bridge: vector table of PIO transactions plus reset/stray corner sequences
module tb_class_hasht_pio_bridge;
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pio_req = 1'b0;
  logic         pio_rd_or_wr = 1'b0;
  logic [16:0]  pio_addr = '0;
  logic [31:0]  pio_wdata = '0;
  logic         pio_ack;
  logic [31:0]  pio_rdata;
  logic         busy;
  logic         req;
  logic         rd_or_wr;
  logic [16:0]  addr;
  logic [127:0] wdata;
  logic         ack = 1'b0;
  logic [31:0]  rdata = '0;
  logic         err_timeout;
  logic         err_overrun;
  logic         err_stray;
  logic         err_clr = 1'b0;
  int total = 0;
  int bad = 0;

  class_hasht_pio_bridge dut (
    .clk(clk), .rst_n(rst_n), .pio_req(pio_req), .pio_rd_or_wr(pio_rd_or_wr),
    .pio_addr(pio_addr), .pio_wdata(pio_wdata), .pio_ack(pio_ack), .pio_rdata(pio_rdata),
    .busy(busy), .req(req), .rd_or_wr(rd_or_wr), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err_timeout(err_timeout), .err_overrun(err_overrun),
    .err_stray(err_stray), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rw;
    logic [16:0]  a;
    logic [31:0]  wd;
    int           k;
    logic [31:0]  ack_rd;
    int           ovr_c;
    int           clr_c;
    int           lat;
    logic [31:0]  exp_rd;
    int           nreq;
    logic [127:0] exp_wd;
    logic         e_to;
    logic         e_ovr;
    logic         e_stray;
  } vec_t;

  vec_t vecs [13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic run(input int idx, input vec_t v);
    int ack_c, req_c, nreq, npack;
    logic [31:0] got_rd;
    logic [127:0] got_wd;
    logic [16:0] got_a;
    logic got_rw, bok;
    ack_c = 0; req_c = 0; nreq = 0; npack = 0; bok = 1'b1;
    got_rd = '0; got_wd = '0; got_a = '0; got_rw = 1'b0;
    pio_req = 1'b1; pio_rd_or_wr = v.rw; pio_addr = v.a; pio_wdata = v.wd;
    step();
    pio_req = 1'b0;
    for (int c = 1; c <= 200 && (ack_c == 0 || c <= ack_c + 1); c++) begin
      if (req) begin nreq++; req_c = c; got_wd = wdata; got_a = addr; got_rw = rd_or_wr; end
      if (pio_ack) begin npack++; if (ack_c == 0) begin ack_c = c; got_rd = pio_rdata; end end
      if (busy !== (ack_c == 0 || c == ack_c)) bok = 1'b0;
      pio_req = (c == v.ovr_c);
      err_clr = (c == v.clr_c);
      ack = (v.k >= 0 && req_c > 0 && c == req_c + v.k);
      rdata = v.ack_rd;
      step();
    end
    pio_req = 1'b0; err_clr = 1'b0; ack = 1'b0;
    chk($sformatf("v%0d latency", idx), 128'(ack_c), 128'(v.lat));
    chk($sformatf("v%0d pio_rdata", idx), got_rd, v.exp_rd);
    chk($sformatf("v%0d req_count", idx), 128'(nreq), 128'(v.nreq));
    chk($sformatf("v%0d pio_ack_count", idx), 128'(npack), 128'd1);
    chk($sformatf("v%0d busy", idx), bok, 1'b1);
    if (v.nreq > 0) begin
      chk($sformatf("v%0d addr", idx), got_a, v.a);
      chk($sformatf("v%0d rd_or_wr", idx), got_rw, v.rw);
      if (v.rw == WR) chk($sformatf("v%0d wdata", idx), got_wd, v.exp_wd);
    end
    chk($sformatf("v%0d err_timeout", idx), err_timeout, v.e_to);
    chk($sformatf("v%0d err_overrun", idx), err_overrun, v.e_ovr);
    chk($sformatf("v%0d err_stray", idx), err_stray, v.e_stray);
  endtask

  initial begin
    int npack;
    vecs[0]  = '{RD, 17'h108, 32'h0, 4, 32'hA5A5_0001, 0, 0, 6, 32'hA5A5_0001, 1, 128'h0, 0, 0, 0};
    vecs[1]  = '{WR, 17'h200, 32'h11, -1, 32'h0, 0, 0, 1, 32'h0, 0, 128'h0, 0, 0, 0};
    vecs[2]  = '{WR, 17'h204, 32'h22, -1, 32'h0, 0, 0, 1, 32'h0, 0, 128'h0, 0, 0, 0};
    vecs[3]  = '{WR, 17'h208, 32'h33, -1, 32'h0, 0, 0, 1, 32'h0, 0, 128'h0, 0, 0, 0};
    vecs[4]  = '{WR, 17'h20C, 32'h44, 2, 32'hFFFF_FFFF, 0, 0, 4, 32'h0, 1,
                 128'h00000044_00000033_00000022_00000011, 0, 0, 0};
    vecs[5]  = '{RD, 17'h300, 32'h0, 1, 32'hCAFE_0001, 0, 0, 3, 32'hCAFE_0001, 1, 128'h0, 0, 0, 0};
    vecs[6]  = '{WR, 17'h304, 32'h55, -1, 32'h0, 0, 0, 1, 32'h0, 0, 128'h0, 0, 0, 0};
    vecs[7]  = '{WR, 17'h30C, 32'h66, 3, 32'h0, 0, 0, 5, 32'h0, 1,
                 128'h00000066_00000033_00000055_00000011, 0, 0, 0};
    vecs[8]  = '{RD, 17'h410, 32'h0, 64, 32'h1234, 0, 0, 66, 32'h1234, 1, 128'h0, 0, 0, 0};
    vecs[9]  = '{RD, 17'h504, 32'h0, 6, 32'h0BAD_0009, 3, 0, 8, 32'h0BAD_0009, 1, 128'h0, 0, 1, 0};
    vecs[10] = '{RD, 17'h508, 32'h0, 2, 32'h7777_0002, 0, 2, 4, 32'h7777_0002, 1, 128'h0, 0, 0, 0};
    vecs[11] = '{RD, 17'h50C, 32'h0, 4, 32'h1357_9BDF, 3, 3, 6, 32'h1357_9BDF, 1, 128'h0, 0, 1, 0};
    vecs[12] = '{RD, 17'h600, 32'h0, -1, 32'h0, 0, 0, 66, 32'hDEAD_BEEF, 1, 128'h0, 1, 1, 0};
    repeat (3) step();
    chk("reset_outputs", {pio_ack, pio_rdata, busy, req, rd_or_wr, addr, wdata[63:0],
        err_timeout, err_overrun, err_stray}, '0);
    chk("reset_wdata_hi", wdata[127:64], '0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 13; i++) run(i, vecs[i]);
    // late ack after the timeout must be flagged stray and produce no completion
    ack = 1'b1;
    step();
    ack = 1'b0;
    npack = 0;
    for (int c = 0; c < 4; c++) begin
      if (pio_ack) npack++;
      step();
    end
    chk("late_ack_pio_ack_count", 128'(npack), 128'd0);
    chk("late_ack_err_stray", err_stray, 1'b1);
    pio_req = 1'b1; pio_rd_or_wr = RD; pio_addr = 17'h700;
    step();
    pio_req = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("midwait_reset_outputs", {pio_ack, pio_rdata, busy, req, rd_or_wr, addr, wdata[63:0],
        err_timeout, err_overrun, err_stray}, '0);
    chk("midwait_reset_wdata_hi", wdata[127:64], '0);
    rst_n = 1'b1;
    ack = 1'b1;
    rdata = 32'h5555_AAAA;
    step();
    ack = 1'b0;
    npack = 0;
    for (int c = 0; c < 4; c++) begin
      if (pio_ack) npack++;
      step();
    end
    chk("post_reset_ack_pio_ack_count", 128'(npack), 128'd0);
    chk("post_reset_ack_err_stray", err_stray, 1'b1);
    chk("post_reset_busy", busy, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
